// File: rtl/gate_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gate_scan_sequencer
//  Purpose  : Steps a gate delay through N values, starting at base_delay
//             and adding step_delta each time. The sequencer stays on each
//             step for M counted (non-background) frames, then moves on. Each
//             new delay is presented on gate_delay_o with a one-cycle
//             load_param strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   1   single clock
//    rst              in   1   synchronous active-high reset
//    start            in   1   one-cycle scan request (accepted in IDLE only)
//    abort            in   1   terminates any scan, highest priority
//    base_delay       in  32   first gate delay (clk ticks)
//    step_delta       in   8   delay increment per step (zero-extended)
//    step_count       in  16   number of delay steps N
//    frames_per_step  in   8   counted frames per step M
//    frame_ext_trig   in   1   frame trigger, rising edge = frame boundary
//    frame_type       in   2   01=A, 10=B, 00=background (ignored)
//    gate_delay_o     out 32   delay to load into the gate generator
//    load_param       out  1   strobe: gate_delay_o valid, latch it
//    step_idx         out 16   current step index 0..N-1
//    busy             out  1   high in every state except IDLE
//    done             out  1   one-cycle pulse at scan completion
//    err_cfg          out  1   one-cycle pulse when start is rejected
// ============================================================================
module gate_scan_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base_delay,
  input  logic [7:0]  step_delta,
  input  logic [15:0] step_count,
  input  logic [7:0]  frames_per_step,
  input  logic        frame_ext_trig,
  input  logic [1:0]  frame_type,
  output logic [31:0] gate_delay_o,
  output logic        load_param,
  output logic [15:0] step_idx,
  output logic        busy,
  output logic        done,
  output logic        err_cfg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;

  // Shadow copies of the configuration, captured only when a scan starts.
  logic [31:0] base_q;
  logic [7:0]  delta_q;
  logic [15:0] n_q;
  logic [7:0]  m_q;

  logic [31:0] gate_delay_q;
  logic [15:0] step_idx_q;
  logic [7:0]  frame_cnt_q;
  logic        load_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // Previous-cycle trigger. Resets high so a trigger already asserted when
  // reset is released does not look like a rising edge.
  logic        trig_dly_q;

  // Set when a counted boundary lands in the cycle right after a load_param
  // strobe; the boundary is then processed one cycle later so load_param can
  // never be high on two consecutive cycles. A new rising edge cannot occur
  // in the deferred cycle because the trigger is still high.
  logic        pend_q;

  logic        w_boundary;
  logic        w_counted;
  logic        w_event;
  logic        w_last_frame;
  logic        w_last_step;
  logic        w_cfg_bad;
  logic [32:0] w_sum;
  logic [31:0] w_next_delay;

  assign w_boundary   = frame_ext_trig & ~trig_dly_q;
  assign w_counted    = w_boundary & (frame_type != 2'b00);
  assign w_event      = w_counted | pend_q;
  assign w_last_frame = (frame_cnt_q == (m_q - 8'd1));
  assign w_last_step  = (step_idx_q == (n_q - 16'd1));
  assign w_cfg_bad    = (step_count == 16'd0) || (frames_per_step == 8'd0);

  // 33-bit sum: the carry bit marks overflow and the result clamps to all ones.
  assign w_sum        = {1'b0, gate_delay_q} + {25'd0, delta_q};
  assign w_next_delay = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= 32'd0;
      delta_q      <= 8'd0;
      n_q          <= 16'd0;
      m_q          <= 8'd0;
      gate_delay_q <= 32'd0;
      step_idx_q   <= 16'd0;
      frame_cnt_q  <= 8'd0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      trig_dly_q   <= 1'b1;
      pend_q       <= 1'b0;
    end else begin
      trig_dly_q <= frame_ext_trig;
      // Strobes default low so each is at most one cycle wide.
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A start arriving while err_cfg is high is ignored so that
          // err_cfg cannot pulse on two consecutive cycles.
          if (!abort && start && !err_q) begin
            if (w_cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              base_q  <= base_delay;
              delta_q <= step_delta;
              n_q     <= step_count;
              m_q     <= frames_per_step;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          pend_q <= 1'b0;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // Any boundary seen in this cycle is deliberately not counted.
            gate_delay_q <= base_q;
            step_idx_q   <= 16'd0;
            frame_cnt_q  <= 8'd0;
            load_q       <= 1'b1;
            state_q      <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (w_event) begin
            if (load_q) begin
              pend_q <= 1'b1;
            end else begin
              pend_q <= 1'b0;
              if (w_last_frame) begin
                if (w_last_step) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  step_idx_q   <= step_idx_q + 16'd1;
                  gate_delay_q <= w_next_delay;
                  frame_cnt_q  <= 8'd0;
                  load_q       <= 1'b1;
                end
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
        end

        S_DONE: begin
          // done is already high this cycle; just return to IDLE.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_delay_o = gate_delay_q;
  assign load_param   = load_q;
  assign step_idx     = step_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_cfg      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gate_scan_sequencer
//  Purpose  : Directed self-checking bench for gate_scan_sequencer. Expected
//             output events (load_param with delay/index, done, err_cfg) are
//             queued just before the stimulus that should cause them and are
//             popped by a monitor whenever the DUT pulses an output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] base_delay;
  logic [7:0]  step_delta;
  logic [15:0] step_count;
  logic [7:0]  frames_per_step;
  logic        frame_ext_trig;
  logic [1:0]  frame_type;
  logic [31:0] gate_delay_o;
  logic        load_param;
  logic [15:0] step_idx;
  logic        busy;
  logic        done;
  logic        err_cfg;

  gate_scan_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .base_delay      (base_delay),
    .step_delta      (step_delta),
    .step_count      (step_count),
    .frames_per_step (frames_per_step),
    .frame_ext_trig  (frame_ext_trig),
    .frame_type      (frame_type),
    .gate_delay_o    (gate_delay_o),
    .load_param      (load_param),
    .step_idx        (step_idx),
    .busy            (busy),
    .done            (done),
    .err_cfg         (err_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event kinds: 0 = load_param, 1 = done, 2 = err_cfg
  typedef struct {
    int          kind;
    logic [31:0] d;
    logic [15:0] i;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input logic [31:0] d, input logic [15:0] i);
    ev_t e;
    e.kind = 0; e.d = d; e.i = i;
    q.push_back(e);
  endtask

  task automatic push_kind(input int k);
    ev_t e;
    e.kind = k; e.d = 32'd0; e.i = 16'd0;
    q.push_back(e);
  endtask

  // Drives a start pulse for one cycle; returns at the following negedge.
  task automatic do_start(input logic [31:0] b, input logic [7:0] dl,
                          input logic [15:0] n, input logic [7:0] m);
    base_delay = b; step_delta = dl; step_count = n; frames_per_step = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One frame: trigger high for one cycle, then low for three.
  task automatic frame(input logic [1:0] t);
    frame_type = t;
    frame_ext_trig = 1'b1;
    @(negedge clk);
    frame_ext_trig = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  logic prev_l = 1'b0, prev_d = 1'b0, prev_e = 1'b0;
  ev_t  e_mon;
  int   kobs;

  always @(negedge clk) begin
    if (!rst && (load_param || done || err_cfg)) begin
      chk("single_pulse", 64'(int'(load_param) + int'(done) + int'(err_cfg)), 64'd1);
      chk("no_back_to_back", {61'd0, load_param & prev_l, done & prev_d, err_cfg & prev_e}, 64'd0);
      chk("event_expected", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        e_mon = q.pop_front();
        kobs  = load_param ? 0 : (done ? 1 : 2);
        chk("event_kind", 64'(kobs), 64'(e_mon.kind));
        if (kobs == 0 && e_mon.kind == 0) begin
          chk("load_delay", {32'd0, gate_delay_o}, {32'd0, e_mon.d});
          chk("load_step", {48'd0, step_idx}, {48'd0, e_mon.i});
        end
      end
    end
    prev_l = load_param;
    prev_d = done;
    prev_e = err_cfg;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    base_delay = 32'd0; step_delta = 8'd0; step_count = 16'd0; frames_per_step = 8'd0;
    frame_ext_trig = 1'b1;          // held high across reset release
    frame_type = 2'b01;
    repeat (3) @(negedge clk);

    // ---- reset state
    chk("rst_gate_delay", {32'd0, gate_delay_o}, 64'd0);
    chk("rst_step_idx", {48'd0, step_idx}, 64'd0);
    chk("rst_strobes", {60'd0, load_param, busy, done, err_cfg}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- trigger held high through reset and start; second start mid-RUN
    push_load(32'd50, 16'd0);
    do_start(32'd50, 8'd3, 16'd2, 8'd1);
    repeat (4) @(negedge clk);
    chk("held_trig_no_count", {48'd0, step_idx}, 64'd0);
    frame_ext_trig = 1'b0;
    repeat (2) @(negedge clk);
    do_start(32'd999, 8'd9, 16'd5, 8'd3);      // must be ignored
    repeat (2) @(negedge clk);
    chk("busy_after_2nd_start", {63'd0, busy}, 64'd1);
    push_load(32'd53, 16'd1);
    frame(2'b01);
    push_kind(1);
    frame(2'b01);
    chk("held_gate_delay", {32'd0, gate_delay_o}, 64'd53);
    chk("held_busy_low", {63'd0, busy}, 64'd0);

    // ---- basic scan base=100 delta=5 N=3 M=2, config scrambled mid-scan
    push_load(32'd100, 16'd0);
    do_start(32'd100, 8'd5, 16'd3, 8'd2);
    base_delay = 32'hDEAD_BEEF; step_delta = 8'hFF; step_count = 16'd1; frames_per_step = 8'd7;
    chk("lat_load_c1", {62'd0, load_param, busy}, 64'd1);
    @(negedge clk);
    chk("lat_load_c2", {63'd0, load_param}, 64'd1);
    repeat (2) @(negedge clk);
    frame(2'b01);
    push_load(32'd105, 16'd1);
    frame(2'b01);
    frame(2'b01);
    push_load(32'd110, 16'd2);
    frame(2'b01);
    frame(2'b01);
    push_kind(1);
    frame_type = 2'b01;
    frame_ext_trig = 1'b1;
    @(negedge clk);
    chk("done_timing", {62'd0, done, busy}, 64'd3);
    frame_ext_trig = 1'b0;
    @(negedge clk);
    chk("done_busy_fall", {62'd0, done, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk("idle_hold_delay", {32'd0, gate_delay_o}, 64'd110);
    chk("idle_hold_step", {48'd0, step_idx}, 64'd2);

    // ---- background frames ignored: N=2 M=1 types A,00,00,B
    push_load(32'd100, 16'd0);
    do_start(32'd100, 8'd1, 16'd2, 8'd1);
    repeat (3) @(negedge clk);
    push_load(32'd101, 16'd1);
    frame(2'b01);
    frame(2'b00);
    frame(2'b00);
    chk("bg_still_busy", {63'd0, busy}, 64'd1);
    push_kind(1);
    frame(2'b10);
    chk("bg_queue_drained", 64'(q.size()), 64'd0);

    // ---- rejected configurations
    push_kind(2);
    do_start(32'd100, 8'd5, 16'd0, 8'd2);
    chk("err_n0_pulse", {62'd0, err_cfg, busy}, 64'd2);
    @(negedge clk);
    chk("err_n0_after", {62'd0, err_cfg, busy}, 64'd0);
    repeat (2) @(negedge clk);
    push_kind(2);
    do_start(32'd100, 8'd5, 16'd3, 8'd0);
    chk("err_m0_pulse", {62'd0, err_cfg, busy}, 64'd2);
    @(negedge clk);
    chk("err_m0_after", {62'd0, err_cfg, busy}, 64'd0);
    repeat (3) @(negedge clk);

    // ---- abort coincident with the 2nd counted boundary
    push_load(32'd100, 16'd0);
    do_start(32'd100, 8'd5, 16'd3, 8'd2);
    repeat (3) @(negedge clk);
    frame(2'b01);
    frame_type = 2'b01;
    frame_ext_trig = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    frame_ext_trig = 1'b0;
    chk("abort_idle", {61'd0, busy, load_param, done}, 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_hold_delay", {32'd0, gate_delay_o}, 64'd100);
    chk("abort_hold_step", {48'd0, step_idx}, 64'd0);

    // ---- saturating addition
    push_load(32'hFFFF_FFFE, 16'd0);
    do_start(32'hFFFF_FFFE, 8'd5, 16'd3, 8'd1);
    repeat (3) @(negedge clk);
    push_load(32'hFFFF_FFFF, 16'd1);
    frame(2'b01);
    push_load(32'hFFFF_FFFF, 16'd2);
    frame(2'b10);
    push_kind(1);
    frame(2'b01);
    chk("sat_final_delay", {32'd0, gate_delay_o}, 64'hFFFF_FFFF);

    // ---- reset mid-scan: no done, outputs cleared, overrides start
    push_load(32'd7, 16'd0);
    do_start(32'd7, 8'd1, 16'd2, 8'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_mid_clear", {16'd0, gate_delay_o, step_idx}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0; start = 1'b0;
    frame(2'b01);
    chk("rst_mid_idle", {62'd0, busy, done}, 64'd0);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_scan_sequencer.md
GATE_SCAN_SEQUENCER -- requirements
Module: gate_scan_sequencer

Interface
REQ-001 SHALL have: clk  in  1  single clock for all logic.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have: start  in  1  one-cycle scan request; only accepted in IDLE.
REQ-004 SHALL have: abort  in  1  level or pulse; terminates any scan.
REQ-005 SHALL have: base_delay  in  32  first gate delay, in clk ticks.
REQ-006 SHALL have: step_delta  in  8  delay increment per step; zero-extended to 32 bits.
REQ-007 SHALL have: step_count  in  16  number of delay steps N.
REQ-008 SHALL have: frames_per_step  in  8  counted frames per step M.
REQ-009 SHALL have: frame_ext_trig  in  1  frame trigger; rising edge = frame boundary.
REQ-010 SHALL have: frame_type  in  2  01=A, 10=B, 00=background.
REQ-011 SHALL have: gate_delay_o  out  32  delay to be loaded into the gate generator.
REQ-012 SHALL have: load_param  out  1  one-cycle strobe: gate_delay_o is valid and must be latched.
REQ-013 SHALL have: step_idx  out  16  current step index, 0..N-1.
REQ-014 SHALL have: busy  out  1  high in every state except IDLE.
REQ-015 SHALL have: done  out  1  one-cycle pulse on scan completion.
REQ-016 SHALL have: err_cfg  out  1  one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-018 SHALL register frame_ext_trig every cycle in all states (trig_d); a boundary SHALL be trig=1 and trig_d=0 in the same cycle.
REQ-019 IDLE + start, N!=0 and M!=0: SHALL latch base_delay, step_delta, N and M into shadow registers, then go to LOAD.
REQ-020 IDLE + start with N==0 or M==0: SHALL pulse err_cfg in the next cycle and remain in IDLE.
REQ-021 LOAD (one cycle): SHALL set gate_delay_o=base, step_idx=0, frame_cnt=0, pulse load_param, then go to RUN.
- Result: load_param is high exactly 2 cycles after start was sampled.
REQ-022 In RUN, frame_cnt SHALL increment only on a boundary whose frame_type is not 00; background frames SHALL be ignored.
REQ-023 In RUN, when a counted boundary occurs and frame_cnt==M-1 and step_idx<N-1, the next cycle SHALL:
- set step_idx+1;
- set gate_delay_o to gate_delay_o+step_delta;
- set frame_cnt=0;
- pulse load_param.
REQ-024 In RUN, when a counted boundary occurs and frame_cnt==M-1 and step_idx==N-1: SHALL go to DONE with no load_param.
REQ-025 DONE (one cycle): SHALL pulse done, then return to IDLE.
REQ-026 The delay addition SHALL saturate at 0xFFFFFFFF instead of wrapping.
REQ-027 gate_delay_o and step_idx SHALL hold their last values in IDLE after DONE or abort.
REQ-028 Abort priority: abort SHALL take priority over start, boundary and DONE.
- Next state is IDLE; no load_param or done is emitted in that cycle.
REQ-029 start while busy SHALL be ignored; the shadow registers SHALL NOT change.
REQ-030 Config inputs changing mid-scan SHALL have no effect.
REQ-031 The boundary detected in the LOAD cycle SHALL be discarded.
REQ-032 load_param, done and err_cfg SHALL never be high for two consecutive cycles.

Reset
REQ-033 Under rst=1 the block SHALL go to IDLE, and these SHALL be 0: gate_delay_o, step_idx, frame_cnt, load_param, busy, done, err_cfg, shadow registers.
REQ-034 trig_d SHALL reset to 1, so a trigger held high through reset creates no boundary.
REQ-035 rst SHALL override abort and start; rst mid-scan SHALL emit no done pulse.

Verification
REQ-036 base=100, delta=5, N=3, M=2, all frames A -> load_param with delays 100, 105, 110; done 1 cycle after the 6th boundary; busy falls with done.
REQ-037 N=2, M=1, frame_type sequence A,00,00,B -> the 00 frames are skipped; the step to 101 follows the A frame; done follows the B frame.
REQ-038 N=0 or M=0 start -> err_cfg pulses once; busy stays 0; no load_param.
REQ-039 abort on the same cycle as the 2nd counted boundary (N=3, M=2) -> no load_param, no done; IDLE next cycle; gate_delay_o holds 100.
REQ-040 base=0xFFFFFFFE, delta=5, N=3, M=1 -> delays 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF.
REQ-041 frame_ext_trig held high across rst release and start; a second start issued mid-RUN -> no spurious count; the second start has no effect.
